bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//   Two-master arbiter and signal mux for the shared serial system bus. Grants the
//   bus round-robin and steers the granted master's serial write/mode/valid lines
//   onto the bus. Routes the slave's serial read data and valid back to that master.
//   An idle watchdog reclaims the bus from a granted master that stops driving mvalid.
// PARAMETERS
//   TIMEOUT  16  consecutive granted cycles with mvalid=0 before the grant is revoked (>=2)
// PORTS
//   clk         in   1  system clock; all state updates on rising edge
//   rst         in   1  reset, synchronous, active-high
//   breq1       in   1  master 1 bus request (level; held for whole transaction)
//   breq2       in   1  master 2 bus request
//   bgrant1     out  1  master 1 owns bus (registered)
//   bgrant2     out  1  master 2 owns bus (registered)
//   msel        out  1  0 = master 1 selected, 1 = master 2 selected (registered)
//   timeout1    out  1  one-cycle pulse: master 1 grant revoked by watchdog
//   timeout2    out  1  one-cycle pulse: master 2 grant revoked by watchdog
//   m1_wdata    in   1  master 1 serial write bit (addr/data, LSB first)
//   m1_mode     in   1  master 1 mode: 1 = write, 0 = read
//   m1_mvalid   in   1  master 1 bit valid
//   m2_wdata, m2_mode, m2_mvalid   in  1 each  master 2 equivalents
//   bus_wdata   out  1  shared bus serial write bit to slaves
//   bus_mode    out  1  shared bus mode
//   bus_mvalid  out  1  shared bus master-valid
//   bus_rdata   in   1  slave serial read bit
//   bus_svalid  in   1  slave read-valid
//   m1_rdata, m1_svalid   out  1 each  read return to master 1
//   m2_rdata, m2_svalid   out  1 each  read return to master 2
// BEHAVIOUR
//   - States: IDLE, GNT1, GNT2. bgrant1 = (state==GNT1), bgrant2 = (state==GNT2); never both 1.
//   - Reset: state IDLE, grants 0, msel 0, timeouts 0, idle counter 0, lockouts cleared,
//     last-granted = master 2 (so master 1 wins first tie). Reset mid-transfer aborts it.
//   - Eligible x = breqx & ~lockx. Request sampled at edge N -> grant visible after edge N.
//   - IDLE: one eligible -> grant it; both -> grant the one not last-granted; none -> stay.
//   - GNTx: stay while breqx=1 and no timeout. On release (breqx=0) or timeout: go to the
//     other master's GNT state if it is eligible (direct handover, zero idle cycles, no
//     overlap), else IDLE. Update last-granted on every grant.
//   - Watchdog: counter clears on entering GNTx and on any cycle with granted mx_mvalid=1;
//     increments otherwise. When counter == TIMEOUT-1 with mvalid=0: revoke grant, pulse
//     timeoutx for one cycle, set lockx. lockx clears on first cycle breqx=0. Counter width
//     $clog2(TIMEOUT); counter held at 0 outside GNT states.
//   - msel updates with grant; holds last value in IDLE.
//   - Forward mux (combinational from registered grant): GNT1 -> bus_* = m1_*; GNT2 -> m2_*;
//     IDLE -> bus_wdata = bus_mode = bus_mvalid = 0.
//   - Return path: mx_rdata = bus_rdata & bgrantx; mx_svalid = bus_svalid & bgrantx;
//     ungranted master sees 0. All outputs are 0 during/after reset.
// TESTING
//   1 Reset: rst=1 two cycles with breq1=breq2=1 -> bgrant1=bgrant2=0, bus_mvalid=0, msel=0.
//   2 Single: breq1=1 at edge 0 -> bgrant1=1 after edge 0; m1 sends 12-bit addr 0x4D5 +
//     data 0xD5 LSB first -> identical bits on bus_wdata, bus_mode=1; breq1=0 -> bgrant1=0 next edge.
//   3 Tie/round-robin: both request from reset -> GNT1; breq1 drops with breq2=1 -> bgrant2=1
//     next edge, no overlap cycle; then M2 drops and both request -> GNT1 again.
//   4 Watchdog (TIMEOUT=8): M1 granted, m1_mvalid=0 8 cycles -> grant drops, timeout1 one
//     pulse; breq1 held -> not regranted; breq1 low 1 cycle then high -> regranted.
//   5 Read return: M2 granted, read addr sent, bus_rdata/bus_svalid driven -> m2_rdata/m2_svalid
//     follow exactly; m1_rdata=m1_svalid=0 throughout.
//   6 Reset mid-write (after 5 addr bits) -> IDLE next edge, bus_mvalid=0, M1 wins next tie.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with serial signal mux, read-return routing and idle watchdog.
// Latency: grant registered one edge after request; forward/return muxes combinational from the grant.
// Backpressure: none; losing master waits on its level request, idle owner reclaimed after TIMEOUT cycles.
module bus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic breq1,
    input  logic breq2,
    output logic bgrant1,
    output logic bgrant2,
    output logic msel,
    output logic timeout1,
    output logic timeout2,
    input  logic m1_wdata,
    input  logic m1_mode,
    input  logic m1_mvalid,
    input  logic m2_wdata,
    input  logic m2_mode,
    input  logic m2_mvalid,
    output logic bus_wdata,
    output logic bus_mode,
    output logic bus_mvalid,
    input  logic bus_rdata,
    input  logic bus_svalid,
    output logic m1_rdata,
    output logic m1_svalid,
    output logic m2_rdata,
    output logic m2_svalid
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    // One-hot grant encoding so each grant output is a plain register bit.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT1 = 2'b01,
        GNT2 = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            last2;
    logic            lock1;
    logic            lock2;
    logic            elig1;
    logic            elig2;
    logic            fire1;
    logic            fire2;
    logic            gnt_mvalid;

    assign elig1 = breq1 & ~lock1;
    assign elig2 = breq2 & ~lock2;

    assign gnt_mvalid = (state == GNT1) ? m1_mvalid :
                        (state == GNT2) ? m2_mvalid : 1'b0;
    assign fire1 = (state == GNT1) & ~m1_mvalid & (cnt == CNT_LAST);
    assign fire2 = (state == GNT2) & ~m2_mvalid & (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (elig1 && elig2) begin
                    state_nxt = last2 ? GNT1 : GNT2;
                end else if (elig1) begin
                    state_nxt = GNT1;
                end else if (elig2) begin
                    state_nxt = GNT2;
                end
            end
            GNT1: begin
                if (!breq1 || fire1) begin
                    state_nxt = elig2 ? GNT2 : IDLE;
                end
            end
            GNT2: begin
                if (!breq2 || fire2) begin
                    state_nxt = elig1 ? GNT1 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter restarts on every new grant, including a direct handover.
    always_comb begin
        cnt_nxt = '0;
        if (state_nxt != IDLE && state_nxt == state && !gnt_mvalid) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            last2    <= 1'b1;
            lock1    <= 1'b0;
            lock2    <= 1'b0;
            msel     <= 1'b0;
            timeout1 <= 1'b0;
            timeout2 <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            timeout1 <= fire1;
            timeout2 <= fire2;
            if (state_nxt == GNT1) begin
                last2 <= 1'b0;
                msel  <= 1'b0;
            end else if (state_nxt == GNT2) begin
                last2 <= 1'b1;
                msel  <= 1'b1;
            end
            // A revoked master must drop its request once before it may win again.
            if (!breq1) begin
                lock1 <= 1'b0;
            end else if (fire1) begin
                lock1 <= 1'b1;
            end
            if (!breq2) begin
                lock2 <= 1'b0;
            end else if (fire2) begin
                lock2 <= 1'b1;
            end
        end
    end

    always_comb begin
        bgrant1    = state[0];
        bgrant2    = state[1];
        bus_wdata  = 1'b0;
        bus_mode   = 1'b0;
        bus_mvalid = 1'b0;
        if (state == GNT1) begin
            bus_wdata  = m1_wdata;
            bus_mode   = m1_mode;
            bus_mvalid = m1_mvalid;
        end else if (state == GNT2) begin
            bus_wdata  = m2_wdata;
            bus_mode   = m2_mode;
            bus_mvalid = m2_mvalid;
        end
        m1_rdata  = bus_rdata  & state[0];
        m1_svalid = bus_svalid & state[0];
        m2_rdata  = bus_rdata  & state[1];
        m2_svalid = bus_svalid & state[1];
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter with TIMEOUT=8.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic breq1, breq2;
    logic bgrant1, bgrant2, msel, timeout1, timeout2;
    logic m1_wdata, m1_mode, m1_mvalid;
    logic m2_wdata, m2_mode, m2_mvalid;
    logic bus_wdata, bus_mode, bus_mvalid;
    logic bus_rdata, bus_svalid;
    logic m1_rdata, m1_svalid, m2_rdata, m2_svalid;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .breq1(breq1), .breq2(breq2),
        .bgrant1(bgrant1), .bgrant2(bgrant2), .msel(msel),
        .timeout1(timeout1), .timeout2(timeout2),
        .m1_wdata(m1_wdata), .m1_mode(m1_mode), .m1_mvalid(m1_mvalid),
        .m2_wdata(m2_wdata), .m2_mode(m2_mode), .m2_mvalid(m2_mvalid),
        .bus_wdata(bus_wdata), .bus_mode(bus_mode), .bus_mvalid(bus_mvalid),
        .bus_rdata(bus_rdata), .bus_svalid(bus_svalid),
        .m1_rdata(m1_rdata), .m1_svalid(m1_svalid),
        .m2_rdata(m2_rdata), .m2_svalid(m2_svalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [19:0] wvec;
    logic [5:0]  rvec;
    logic [5:0]  svec;

    initial begin
        wvec = {8'hD5, 12'h4D5};
        rvec = 6'b101101;
        svec = 6'b110111;
        rst = 1'b1;
        breq1 = 1'b1; breq2 = 1'b1;
        m1_wdata = 1'b0; m1_mode = 1'b0; m1_mvalid = 1'b0;
        m2_wdata = 1'b0; m2_mode = 1'b0; m2_mvalid = 1'b0;
        bus_rdata = 1'b0; bus_svalid = 1'b0;

        // Reset held two cycles with both masters requesting
        step();
        step();
        chk("rst_bgrant1", bgrant1, 0);
        chk("rst_bgrant2", bgrant2, 0);
        chk("rst_bus_mvalid", bus_mvalid, 0);
        chk("rst_msel", msel, 0);
        chk("rst_timeout1", timeout1, 0);

        // Single master write transaction
        rst = 1'b0;
        breq2 = 1'b0;
        step();
        chk("single_grant", bgrant1, 1);
        chk("single_msel", msel, 0);
        for (int i = 0; i < 20; i++) begin
            m1_wdata = wvec[i]; m1_mode = 1'b1; m1_mvalid = 1'b1;
            m2_wdata = ~wvec[i]; m2_mode = 1'b0; m2_mvalid = 1'b0;
            #1;
            chk($sformatf("single_wdata%0d", i), bus_wdata, wvec[i]);
            step();
        end
        chk("single_mode", bus_mode, 1);
        chk("single_mvalid", bus_mvalid, 1);
        m1_mvalid = 1'b0; m1_mode = 1'b0; m1_wdata = 1'b0; m2_wdata = 1'b0;
        breq1 = 1'b0;
        step();
        chk("single_release", bgrant1, 0);
        chk("single_idle_mvalid", bus_mvalid, 0);

        // Tie from reset, handover, round-robin
        rst = 1'b1; breq1 = 1'b1; breq2 = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("tie_gnt1", bgrant1, 1);
        chk("tie_not_gnt2", bgrant2, 0);
        breq1 = 1'b0;
        step();
        chk("hand_gnt1_off", bgrant1, 0);
        chk("hand_gnt2_on", bgrant2, 1);
        chk("hand_msel", msel, 1);
        breq2 = 1'b0;
        step();
        chk("rr_idle_gnt2", bgrant2, 0);
        chk("rr_idle_msel_hold", msel, 1);
        breq1 = 1'b1; breq2 = 1'b1;
        step();
        chk("rr_gnt1", bgrant1, 1);
        chk("rr_msel", msel, 0);

        // Watchdog: M1 idle on the bus for 8 cycles
        breq2 = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("wd_hold%0d", i), bgrant1, 1);
            chk($sformatf("wd_nopulse%0d", i), timeout1, 0);
        end
        step();
        chk("wd_revoked", bgrant1, 0);
        chk("wd_pulse", timeout1, 1);
        chk("wd_no_t2", timeout2, 0);
        step();
        chk("wd_pulse_end", timeout1, 0);
        chk("wd_locked", bgrant1, 0);
        step();
        chk("wd_still_locked", bgrant1, 0);
        breq1 = 1'b0;
        step();
        chk("wd_unlock_idle", bgrant1, 0);
        breq1 = 1'b1;
        step();
        chk("wd_regrant", bgrant1, 1);

        // Read return to M2
        breq1 = 1'b0;
        step();
        breq2 = 1'b1;
        step();
        chk("rd_gnt2", bgrant2, 1);
        for (int i = 0; i < 4; i++) begin
            m2_wdata = i[0]; m2_mode = 1'b0; m2_mvalid = 1'b1;
            #1;
            chk($sformatf("rd_addr%0d", i), bus_wdata, i[0]);
            chk($sformatf("rd_mode%0d", i), bus_mode, 0);
            step();
        end
        m2_mvalid = 1'b0; m2_wdata = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus_rdata = rvec[i]; bus_svalid = svec[i];
            #1;
            chk($sformatf("rd_m2_rdata%0d", i), m2_rdata, rvec[i]);
            chk($sformatf("rd_m2_svalid%0d", i), m2_svalid, svec[i]);
            chk($sformatf("rd_m1_quiet%0d", i), {m1_rdata, m1_svalid}, 0);
            step();
        end
        bus_rdata = 1'b0; bus_svalid = 1'b0;
        breq2 = 1'b0;
        step();

        // Reset in the middle of an M1 write
        breq1 = 1'b1;
        step();
        chk("mid_gnt1", bgrant1, 1);
        for (int i = 0; i < 5; i++) begin
            m1_wdata = wvec[i]; m1_mode = 1'b1; m1_mvalid = 1'b1;
            step();
        end
        rst = 1'b1; breq2 = 1'b1;
        step();
        chk("mid_rst_gnt1", bgrant1, 0);
        chk("mid_rst_mvalid", bus_mvalid, 0);
        chk("mid_rst_msel", msel, 0);
        rst = 1'b0;
        step();
        chk("mid_tie_gnt1", bgrant1, 1);
        chk("mid_tie_gnt2", bgrant2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
